tail_light_seq_ctrl: RTL and testbench
======================================

Name: tail_light_seq_ctrl

Overview:
Sequencing controller for the 3-lamp-per-side tail-light datapath. It arbitrates the driver's left, right, hazard and brake requests into a single operating mode, and times the 4-phase lamp sequence with a prescaler. It drives the left and right lamp banks directly with registered outputs. It sits between the switch/debounce logic and the lamp drivers, and replaces free-running counter sequencing with request-aware, glitch-free mode changes.

Parameters:
TICK_DIV, 4, clocks per sequence phase (integer >= 1)
DIV_W, 8, width of the prescaler counter; must satisfy 2^DIV_W >= TICK_DIV

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req_left  input  1  left turn request, level, synchronous to clk
req_right  input  1  right turn request, level
req_haz  input  1  hazard request, level
brake  input  1  brake pedal, level
l  output  3  left lamps, l[0] innermost, registered
r  output  3  right lamps, r[0] innermost, registered
mode  output  2  current mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZ
phase  output  2  current sequence phase, 0..3
tick  output  1  one-cycle pulse on each phase advance
busy  output  1  1 when mode != IDLE

Behaviour:
- Reset (reset=0, asynchronous): mode=IDLE, phase=0, prescaler=0, tick=0, l=000, r=000, busy=0. All outputs hold these values while reset=0. Release is synchronous at the first posedge with reset=1.
- Requested mode (combinational):
  - req_haz=1, or req_left=1 and req_right=1 -> HAZ
  - else req_left=1 -> LEFT
  - else req_right=1 -> RIGHT
  - else IDLE
- Prescaler:
  - Cleared to 0 in IDLE.
  - In active modes it counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the cycle in which the prescaler equals TICK_DIV-1 in an active mode.
  - TICK_DIV=1 gives tick every cycle.
- Phase: increments mod 4 on each tick. It is cleared to 0 on any mode change.
- Mode transitions (evaluated on each clk edge):
  - IDLE -> requested mode at the next edge if requested != IDLE; phase=0, prescaler=0.
  - Any active mode -> HAZ immediately at the next edge when requested=HAZ and mode != HAZ; phase=0, prescaler=0. Hazard pre-empts mid-sequence.
  - All other changes (to IDLE, LEFT<->RIGHT, HAZ->LEFT/RIGHT) are deferred to the edge where tick=1 and phase=3. At that edge mode takes the requested value and phase becomes 0.
  - If requested equals the current mode at that edge, the sequence continues with phase 0.
  - A request that appears and disappears before the phase-3 tick is ignored.
- Lamp decode: registered, with 1-cycle latency from mode/phase/brake.
  - Active-side pattern by phase: 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111.
  - LEFT: l = pattern(phase); r = brake ? 111 : 000.
  - RIGHT: r = pattern(phase); l = brake ? 111 : 000.
  - HAZ: l = r = phase[0] ? 111 : 000. Brake is ignored.
  - IDLE: l = r = brake ? 111 : 000.
- busy and mode are decoded from the mode register (no extra latency). phase is the phase register.
- Reset asserted mid-sequence aborts immediately. After release the block starts in IDLE regardless of the request inputs; requests are re-sampled at the next edge.

Test Plan:
- TICK_DIV=4, reset released, req_left held: mode=01 one edge after the first sampled request; phase advances every 4 clocks; l sequence 000,001,011,111,000 (each held 4 cycles, lagging phase by 1 clock); r=000; busy=1.
- LEFT active, brake pulsed high for 6 cycles: r=111 one clock after brake rises and 000 one clock after it falls; l sequence unaffected. Same stimulus in IDLE: l=r=111.
- LEFT at phase 2, req_haz raised: next edge mode=11, phase=0, prescaler=0; then l=r toggle 000/111 every 4 clocks with brake=1 having no effect.
- LEFT at phase 1, req_left dropped: mode stays 01 through phases 2 and 3; mode=00 and phase=0 at the phase-3 tick edge; lamps reach 111 once, then follow brake.
- From IDLE, req_left and req_right asserted in the same cycle: mode=11 at the next edge. Then drop req_right only: mode switches to 01 only at the next phase-3 tick.
- RIGHT at phase 2, reset driven low between edges: l, r, mode, phase, busy go to 0 without a clock edge. Reset released with req_right still high: mode=00 on the first edge, mode=10 on the second edge.

Source files
------------

// File: rtl/tail_light_seq_ctrl.sv
// Tail-light sequencing controller.
// Arbitrates left/right/hazard requests into one operating mode, times the
// 4-phase lamp sequence with a prescaler and drives both lamp banks from
// registers. Mode changes other than entry from IDLE and hazard pre-emption
// wait for the end of a full sequence so lamps never jump mid-pattern.
module tail_light_seq_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int DIV_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_haz,
  input  logic       brake,
  output logic [2:0] l,
  output logic [2:0] r,
  output logic [1:0] mode,
  output logic [1:0] phase,
  output logic       tick,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    HAZ   = 2'b11
  } mode_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  mode_t            mode_reg, mode_next, req_mode;
  logic [1:0]       phase_reg, phase_next;
  logic [DIV_W-1:0] presc_reg, presc_next;
  logic             armed_reg;
  logic             tick_int;
  logic [2:0]       seq_pat;
  logic [2:0]       l_reg, l_next;
  logic [2:0]       r_reg, r_next;

  // Requested mode: hazard wins, and both turn signals together mean hazard.
  always_comb begin
    req_mode = IDLE;
    if (req_haz || (req_left && req_right)) begin
      req_mode = HAZ;
    end else if (req_left) begin
      req_mode = LEFT;
    end else if (req_right) begin
      req_mode = RIGHT;
    end
  end

  // Phase advance happens on the last prescaler count of an active mode.
  assign tick_int = (mode_reg != IDLE) && (presc_reg == PRESC_LAST);

  // State register; armed_reg keeps the first edge after reset release in IDLE
  // so requests are only sampled from the following edge on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg  <= IDLE;
      phase_reg <= 2'd0;
      presc_reg <= '0;
      armed_reg <= 1'b0;
    end else begin
      mode_reg  <= mode_next;
      phase_reg <= phase_next;
      presc_reg <= presc_next;
      armed_reg <= 1'b1;
    end
  end

  // Next-state logic: entry from IDLE, hazard pre-emption, deferred changes
  // at the end of phase 3, otherwise ordinary prescaler/phase counting.
  always_comb begin
    mode_next  = mode_reg;
    phase_next = phase_reg;
    presc_next = presc_reg;
    if (mode_reg == IDLE) begin
      phase_next = 2'd0;
      presc_next = '0;
      if (armed_reg && (req_mode != IDLE)) begin
        mode_next = req_mode;
      end
    end else if ((req_mode == HAZ) && (mode_reg != HAZ)) begin
      mode_next  = HAZ;
      phase_next = 2'd0;
      presc_next = '0;
    end else if (tick_int) begin
      presc_next = '0;
      if (phase_reg == 2'd3) begin
        mode_next  = req_mode;
        phase_next = 2'd0;
      end else begin
        phase_next = phase_reg + 2'd1;
      end
    end else begin
      presc_next = presc_reg + DIV_W'(1);
    end
  end

  // Active-side pattern fills from the inside out: lamp gi lights once
  // phase exceeds gi (000, 001, 011, 111).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pat
      assign seq_pat[gi] = (phase_reg > 2'(gi));
    end
  endgenerate

  // Lamp decode from the current mode/phase/brake; registered below.
  always_comb begin
    l_next = brake ? 3'b111 : 3'b000;
    r_next = brake ? 3'b111 : 3'b000;
    case (mode_reg)
      LEFT:  l_next = seq_pat;
      RIGHT: r_next = seq_pat;
      HAZ: begin
        l_next = phase_reg[0] ? 3'b111 : 3'b000;
        r_next = phase_reg[0] ? 3'b111 : 3'b000;
      end
      default: begin
        l_next = brake ? 3'b111 : 3'b000;
        r_next = brake ? 3'b111 : 3'b000;
      end
    endcase
  end

  // Lamp output registers, dark while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_reg <= 3'b000;
      r_reg <= 3'b000;
    end else begin
      l_reg <= l_next;
      r_reg <= r_next;
    end
  end

  assign l     = l_reg;
  assign r     = r_reg;
  assign mode  = mode_reg;
  assign phase = phase_reg;
  assign tick  = tick_int;
  assign busy  = (mode_reg != IDLE);

endmodule

// File: tb/tb_tail_light_seq_ctrl.sv
// Directed bench for tail_light_seq_ctrl with TICK_DIV=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_tail_light_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_left, req_right, req_haz, brake;
  logic [2:0] l, r;
  logic [1:0] mode, phase;
  logic       tick, busy;

  int n_assert = 0;
  int n_fail   = 0;

  tail_light_seq_ctrl #(.TICK_DIV(4), .DIV_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_left (req_left),
    .req_right(req_right),
    .req_haz  (req_haz),
    .brake    (brake),
    .l        (l),
    .r        (r),
    .mode     (mode),
    .phase    (phase),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req_left = 1'b0; req_right = 1'b0; req_haz = 1'b0; brake = 1'b0;
    #2;
    check("rst_mode",  8'(mode),  8'h0);
    check("rst_phase", 8'(phase), 8'h0);
    check("rst_l",     8'(l),     8'h0);
    check("rst_r",     8'(r),     8'h0);
    check("rst_busy",  8'(busy),  8'h0);
    check("rst_tick",  8'(tick),  8'h0);
    step(2);
    reset = 1'b1;
    step(1);
    check("release_idle", 8'(mode), 8'h0);
    req_left = 1'b1;

    // LEFT sequence
    step(1);
    $display("LEFT entry: mode=%0d phase=%0d l=%b r=%b", mode, phase, l, r);
    check("left_mode",  8'(mode),  8'h1);
    check("left_busy",  8'(busy),  8'h1);
    check("left_ph0",   8'(phase), 8'h0);
    check("left_tick0", 8'(tick),  8'h0);
    check("left_l0",    8'(l),     8'h0);
    check("left_r0",    8'(r),     8'h0);
    step(3);
    check("left_tick1", 8'(tick),  8'h1);
    check("left_ph0b",  8'(phase), 8'h0);
    step(1);
    check("left_ph1",   8'(phase), 8'h1);
    check("left_tick2", 8'(tick),  8'h0);
    check("left_l_lag", 8'(l),     8'h0);
    step(1);
    check("left_l001",  8'(l),     8'h1);
    step(4);
    check("left_l011",  8'(l),     8'h3);
    check("left_ph2",   8'(phase), 8'h2);
    step(4);
    check("left_l111",  8'(l),     8'h7);
    check("left_ph3",   8'(phase), 8'h3);
    check("left_r_off", 8'(r),     8'h0);
    step(4);
    check("left_wrap_ph", 8'(phase), 8'h0);
    check("left_wrap_l",  8'(l),     8'h0);
    check("left_wrap_md", 8'(mode),  8'h1);

    // Brake during LEFT
    brake = 1'b1;
    step(1);
    $display("LEFT brake on: l=%b r=%b", l, r);
    check("brk_r_on",   8'(r), 8'h7);
    check("brk_l_seq0", 8'(l), 8'h0);
    step(5);
    check("brk_r_hold", 8'(r), 8'h7);
    check("brk_l_seq1", 8'(l), 8'h1);
    brake = 1'b0;
    step(1);
    check("brk_r_off",  8'(r),     8'h0);
    check("brk_l_seq2", 8'(l),     8'h1);
    check("pre_haz_ph", 8'(phase), 8'h2);

    // Hazard pre-empts at phase 2, brake ignored
    req_haz = 1'b1; brake = 1'b1;
    step(1);
    $display("HAZ preempt: mode=%0d phase=%0d", mode, phase);
    check("haz_mode",  8'(mode),  8'h3);
    check("haz_ph0",   8'(phase), 8'h0);
    check("haz_tick",  8'(tick),  8'h0);
    step(1);
    check("haz_l_off", 8'(l), 8'h0);
    check("haz_r_off", 8'(r), 8'h0);
    step(4);
    check("haz_l_on",  8'(l), 8'h7);
    check("haz_r_on",  8'(r), 8'h7);
    step(4);
    check("haz_l_off2", 8'(l), 8'h0);
    check("haz_r_off2", 8'(r), 8'h0);
    req_haz = 1'b0; brake = 1'b0;
    step(6);
    check("haz_defer_md",  8'(mode),  8'h3);
    check("haz_defer_ph",  8'(phase), 8'h3);
    check("haz_defer_tk",  8'(tick),  8'h1);
    step(1);
    check("haz_to_left",    8'(mode),  8'h1);
    check("haz_to_left_ph", 8'(phase), 8'h0);

    // Drop LEFT at phase 1: finish the sequence, then IDLE
    step(4);
    check("drop_ph1", 8'(phase), 8'h1);
    req_left = 1'b0;
    step(5);
    check("drop_md_ph2", 8'(mode),  8'h1);
    check("drop_ph2",    8'(phase), 8'h2);
    step(6);
    check("drop_md_ph3", 8'(mode),  8'h1);
    check("drop_ph3",    8'(phase), 8'h3);
    check("drop_tick",   8'(tick),  8'h1);
    step(1);
    $display("LEFT->IDLE: mode=%0d phase=%0d l=%b", mode, phase, l);
    check("idle_mode",  8'(mode),  8'h0);
    check("idle_busy",  8'(busy),  8'h0);
    check("idle_ph",    8'(phase), 8'h0);
    check("idle_tick",  8'(tick),  8'h0);
    check("idle_l_111", 8'(l),     8'h7);
    check("idle_r_000", 8'(r),     8'h0);
    step(1);
    check("idle_l_dark", 8'(l), 8'h0);
    brake = 1'b1;
    step(1);
    check("idle_brk_l", 8'(l), 8'h7);
    check("idle_brk_r", 8'(r), 8'h7);
    brake = 1'b0;
    step(1);
    check("idle_rel_l", 8'(l), 8'h0);
    check("idle_rel_r", 8'(r), 8'h0);

    // Both turn requests together mean hazard
    req_left = 1'b1; req_right = 1'b1;
    step(1);
    check("both_haz",    8'(mode),  8'h3);
    check("both_haz_ph", 8'(phase), 8'h0);
    req_right = 1'b0;
    step(15);
    check("both_defer_md", 8'(mode), 8'h3);
    check("both_defer_tk", 8'(tick), 8'h1);
    step(1);
    check("both_to_left", 8'(mode), 8'h1);

    // LEFT -> RIGHT deferred to the phase-3 tick
    req_left = 1'b0; req_right = 1'b1;
    step(15);
    check("lr_defer_md", 8'(mode),  8'h1);
    check("lr_defer_ph", 8'(phase), 8'h3);
    step(1);
    check("lr_right", 8'(mode), 8'h2);
    step(8);
    check("right_ph2", 8'(phase), 8'h2);
    check("right_r",   8'(r),     8'h1);
    check("right_l",   8'(l),     8'h0);

    // Asynchronous reset mid-sequence
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: mode=%0d phase=%0d l=%b r=%b busy=%0d", mode, phase, l, r, busy);
    check("arst_mode",  8'(mode),  8'h0);
    check("arst_phase", 8'(phase), 8'h0);
    check("arst_l",     8'(l),     8'h0);
    check("arst_r",     8'(r),     8'h0);
    check("arst_busy",  8'(busy),  8'h0);
    step(1);
    check("arst_hold", 8'(mode), 8'h0);
    reset = 1'b1;
    step(1);
    check("rel_edge1", 8'(mode), 8'h0);
    check("rel_busy1", 8'(busy), 8'h0);
    step(1);
    check("rel_edge2", 8'(mode),  8'h2);
    check("rel_busy2", 8'(busy),  8'h1);
    check("rel_ph",    8'(phase), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
